// File: rtl/eae_unit.sv
// PDP-8/e EAE sequencer: MUY/DIV/NMI/SHL/ASR/LSR one step per EAE1 cycle, write-back strobe in F3; no backpressure.
// Define EAE_MODE_B_EN to honour SWAB/SWBA and the mode-B shift count; otherwise mode A only.
module eae_unit #(
  parameter int WIDTH   = 12,
  parameter int SC_BITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         state,
  input  logic [0:WIDTH-1]   instruction,
  input  logic [0:WIDTH-1]   ac_in,
  input  logic [0:WIDTH-1]   mq_in,
  input  logic               link_in,
  input  logic [0:WIDTH-1]   operand,
  output logic [0:WIDTH-1]   ac_out,
  output logic [0:WIDTH-1]   mq_out,
  output logic               link_out,
  output logic               eae_we,
  output logic [SC_BITS-1:0] sc,
  output logic               EAE_mode,
  output logic               EAE_loop
);

  localparam logic [4:0] EAE0 = 5'd8;
  localparam logic [4:0] EAE1 = 5'd9;

  typedef enum logic [2:0] {
    OP_NONE, OP_MUY, OP_DIV, OP_NMI, OP_SHL, OP_ASR, OP_LSR
  } op_t;

  op_t                 dec_op, op;
  logic [0:WIDTH-1]    w_ac, w_mq, w_opnd;
  logic                w_l;
  logic [5:0]          cnt, n_cnt, shift_cnt;
  logic [0:WIDTH-1]    n_ac, n_mq;
  logic                n_l;
  logic [SC_BITS-1:0]  n_sc;
  logic [WIDTH:0]      add_sum, div_rem;
  logic                div_ge, cur_norm, nxt_norm, mode_b;

  function automatic logic is_norm(input logic [0:WIDTH-1] a, input logic [0:WIDTH-1] m);
    return (a[0] ^ a[1]) || ({a, m} == 24'd0) || ({a, m} == 24'o40000000);
  endfunction

`ifdef EAE_MODE_B_EN
  localparam logic [4:0]       F3   = 5'd3;
  localparam logic [0:WIDTH-1] SWAB = 12'o7431;
  localparam logic [0:WIDTH-1] SWBA = 12'o7447;
  logic mode_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= 1'b0;
    end else if (state == F3) begin
      if (instruction == SWAB)
        mode_q <= 1'b1;
      else if (instruction == SWBA)
        mode_q <= 1'b0;
    end
  end

  assign mode_b = mode_q;
`else
  assign mode_b = 1'b0;
`endif

  assign EAE_mode = mode_b;

  // Only the 74x1 group with bits 6-7 clear carries an arithmetic code in bits 8-10.
  always_comb begin
    dec_op = OP_NONE;
    if (instruction[0:5] == 6'o74 && instruction[6:7] == 2'b00 && instruction[11]) begin
      case (instruction[8:10])
        3'd2:    dec_op = OP_MUY;
        3'd3:    dec_op = OP_DIV;
        3'd4:    dec_op = OP_NMI;
        3'd5:    dec_op = OP_SHL;
        3'd6:    dec_op = OP_ASR;
        3'd7:    dec_op = OP_LSR;
        default: dec_op = OP_NONE;
      endcase
    end
  end

  assign shift_cnt = mode_b ? {1'b0, operand[7:11]} : ({1'b0, operand[7:11]} + 6'd1);

  always_comb begin
    n_ac     = w_ac;
    n_mq     = w_mq;
    n_l      = w_l;
    n_sc     = sc;
    n_cnt    = cnt;
    add_sum  = {1'b0, w_ac} + (w_mq[11] ? {1'b0, w_opnd} : '0);
    div_rem  = {w_ac, w_mq[0]};
    div_ge   = (div_rem >= {1'b0, w_opnd});
    cur_norm = is_norm(w_ac, w_mq);
    if (op == OP_NMI) begin
      if (!cur_norm) begin
        {n_ac, n_mq} = {w_ac[1:11], w_mq, 1'b0};
        n_sc         = sc + SC_BITS'(1);
      end
    end else if (cnt != '0) begin
      n_cnt = cnt - 6'd1;
      case (op)
        OP_MUY: begin
          {n_ac, n_mq} = {add_sum, w_mq[0:10]};
          n_l          = 1'b0;
        end
        OP_DIV: begin
          // Remainder after subtraction is below the divisor, so 12 bits suffice.
          n_ac = div_ge ? (div_rem[WIDTH-1:0] - w_opnd) : div_rem[WIDTH-1:0];
          n_mq = {w_mq[1:11], div_ge};
          n_l  = 1'b0;
        end
        OP_SHL: begin
          {n_ac, n_mq} = {w_ac[1:11], w_mq, 1'b0};
          n_l          = w_ac[0];
        end
        OP_ASR: begin
          {n_ac, n_mq} = {w_ac[0], w_ac, w_mq[0:10]};
          n_l          = w_ac[0];
        end
        OP_LSR: begin
          {n_ac, n_mq} = {1'b0, w_ac, w_mq[0:10]};
          n_l          = 1'b0;
        end
        default: ;
      endcase
    end
    nxt_norm = is_norm(n_ac, n_mq);
  end

  assign EAE_loop = (state == EAE1) && ((op == OP_NMI) ? !nxt_norm : (cnt > 6'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      w_ac     <= '0;
      w_mq     <= '0;
      w_opnd   <= '0;
      w_l      <= 1'b0;
      op       <= OP_NONE;
      cnt      <= '0;
      sc       <= '0;
      ac_out   <= '0;
      mq_out   <= '0;
      link_out <= 1'b0;
      eae_we   <= 1'b0;
    end else begin
      eae_we <= 1'b0;
      if (state == EAE0) begin
        w_ac   <= ac_in;
        w_mq   <= mq_in;
        w_l    <= link_in;
        w_opnd <= operand;
        op     <= dec_op;
        case (dec_op)
          OP_MUY: cnt <= 6'd12;
          OP_DIV: begin
            // Quotient would not fit in 12 bits: flag in link and skip the steps.
            if (ac_in >= operand) begin
              w_l <= 1'b1;
              cnt <= '0;
            end else begin
              cnt <= 6'd12;
            end
          end
          OP_NMI: begin
            cnt <= '0;
            sc  <= '0;
          end
          OP_SHL, OP_ASR, OP_LSR: cnt <= shift_cnt;
          default: cnt <= '0;
        endcase
      end else if (state == EAE1) begin
        w_ac <= n_ac;
        w_mq <= n_mq;
        w_l  <= n_l;
        cnt  <= n_cnt;
        sc   <= n_sc;
        if (!EAE_loop) begin
          ac_out   <= n_ac;
          mq_out   <= n_mq;
          link_out <= n_l;
          eae_we   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_eae_unit.sv
// Directed bench for eae_unit: driver emulates the CPU state sequence, monitor scores each write-back.
module tb_eae_unit;

  localparam logic [4:0] S_IDLE = 5'd0;
  localparam logic [4:0] S_F3   = 5'd3;
  localparam logic [4:0] S_EAE0 = 5'd8;
  localparam logic [4:0] S_EAE1 = 5'd9;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  state;
  logic [0:11] instruction, ac_in, mq_in, operand;
  logic        link_in;
  logic [0:11] ac_out, mq_out;
  logic        link_out, eae_we, EAE_mode, EAE_loop;
  logic [4:0]  sc;

  typedef struct {
    string      name;
    logic [11:0] ac;
    logic [11:0] mq;
    logic        l;
    logic [4:0]  sc;
    int          cycles;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_cycles = 0;
  logic prev_we = 1'b0;

  eae_unit dut (
    .clk(clk), .reset(reset), .state(state), .instruction(instruction),
    .ac_in(ac_in), .mq_in(mq_in), .link_in(link_in), .operand(operand),
    .ac_out(ac_out), .mq_out(mq_out), .link_out(link_out), .eae_we(eae_we),
    .sc(sc), .EAE_mode(EAE_mode), .EAE_loop(EAE_loop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0o (octal), required %0o", name, act, want);
    end
  endtask

  // Monitor: every write-back strobe is matched against the oldest expectation.
  always @(negedge clk) begin
    if (eae_we) begin
      check("we_single_cycle", {31'd0, prev_we}, 32'd0);
      check("we_in_f3", {27'd0, state}, {27'd0, S_F3});
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_we: eae_we high with no operation outstanding");
      end else begin
        got = sb.pop_front();
        check({got.name, "_ac"},     {20'd0, ac_out},   {20'd0, got.ac});
        check({got.name, "_mq"},     {20'd0, mq_out},   {20'd0, got.mq});
        check({got.name, "_link"},   {31'd0, link_out}, {31'd0, got.l});
        check({got.name, "_sc"},     {27'd0, sc},       {27'd0, got.sc});
        check({got.name, "_cycles"}, last_cycles,       got.cycles);
      end
    end
    prev_we = eae_we;
  end

  task automatic run_op(input string name, input logic [11:0] instr,
                        input logic [11:0] ac, input logic [11:0] mq, input logic l,
                        input logic [11:0] opnd,
                        input logic [11:0] e_ac, input logic [11:0] e_mq, input logic e_l,
                        input logic [4:0] e_sc, input int e_cyc);
    exp_t ex;
    int   cyc;
    bit   done;
    ex.name = name; ex.ac = e_ac; ex.mq = e_mq; ex.l = e_l; ex.sc = e_sc; ex.cycles = e_cyc;
    sb.push_back(ex);
    @(posedge clk); #1;
    state = S_EAE0; instruction = instr; ac_in = ac; mq_in = mq; link_in = l; operand = opnd;
    @(posedge clk); #1;
    state = S_EAE1;
    cyc = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (!EAE_loop) begin
        done = 1;
      end else if (cyc >= 64) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s_timeout: EAE_loop still 1 after %0d cycles, required 0", name, cyc);
        done = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    last_cycles = cyc;
    @(posedge clk); #1;
    state = S_F3;
    @(posedge clk); #1;
    state = S_IDLE; instruction = 12'o0;
    @(posedge clk); #1;
  endtask

  task automatic mode_instr(input logic [11:0] instr);
    @(posedge clk); #1;
    state = S_F3; instruction = instr;
    @(posedge clk); #1;
    state = S_IDLE; instruction = 12'o0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_mode"}, {31'd0, EAE_mode}, 32'd0);
    check({tag, "_loop"}, {31'd0, EAE_loop}, 32'd0);
    check({tag, "_sc"},   {27'd0, sc},       32'd0);
    check({tag, "_we"},   {31'd0, eae_we},   32'd0);
    check({tag, "_ac"},   {20'd0, ac_out},   32'd0);
    check({tag, "_mq"},   {20'd0, mq_out},   32'd0);
    check({tag, "_link"}, {31'd0, link_out}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; state = S_IDLE; instruction = 12'o0;
    ac_in = 12'o0; mq_in = 12'o0; link_in = 1'b0; operand = 12'o0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    //      name        instr    AC       MQ       L     opnd     exp AC   exp MQ   L     sc     cycles
    run_op("muy",      12'o7405, 12'o0003, 12'o0012, 1'b0, 12'o0005, 12'o0000, 12'o0065, 1'b0, 5'd0,  12);
    run_op("muy_max",  12'o7405, 12'o7777, 12'o7777, 1'b1, 12'o7777, 12'o7777, 12'o0000, 1'b0, 5'd0,  12);
    run_op("div",      12'o7407, 12'o0000, 12'o0144, 1'b1, 12'o0007, 12'o0002, 12'o0016, 1'b0, 5'd0,  12);
    run_op("div_ovf",  12'o7407, 12'o0010, 12'o0144, 1'b0, 12'o0007, 12'o0010, 12'o0144, 1'b1, 5'd0,  1);
    run_op("div_zero", 12'o7407, 12'o0000, 12'o0144, 1'b0, 12'o0000, 12'o0000, 12'o0144, 1'b1, 5'd0,  1);
    run_op("nmi",      12'o7411, 12'o0001, 12'o0000, 1'b0, 12'o0000, 12'o2000, 12'o0000, 1'b0, 5'd10, 10);
    run_op("nmi_zero", 12'o7411, 12'o0000, 12'o0000, 1'b1, 12'o0000, 12'o0000, 12'o0000, 1'b1, 5'd0,  1);
    run_op("nmi_neg",  12'o7411, 12'o7777, 12'o7777, 1'b0, 12'o0000, 12'o4000, 12'o0000, 1'b0, 5'd23, 23);
    run_op("lsr",      12'o7417, 12'o0100, 12'o0000, 1'b1, 12'o0003, 12'o0004, 12'o0000, 1'b0, 5'd23, 4);
    run_op("asr",      12'o7415, 12'o4000, 12'o0000, 1'b0, 12'o0001, 12'o7000, 12'o0000, 1'b1, 5'd23, 2);
    run_op("shl",      12'o7413, 12'o0000, 12'o4001, 1'b1, 12'o0000, 12'o0001, 12'o0002, 1'b0, 5'd23, 1);

    @(negedge clk);
    check("idle_loop", {31'd0, EAE_loop}, 32'd0);

    mode_instr(12'o7431);
    @(negedge clk);
`ifdef EAE_MODE_B_EN
    check("swab_mode", {31'd0, EAE_mode}, 32'd1);
    run_op("shl_b",    12'o7413, 12'o0001, 12'o0000, 1'b0, 12'o0002, 12'o0004, 12'o0000, 1'b0, 5'd23, 2);
    run_op("shl_b0",   12'o7413, 12'o0001, 12'o0000, 1'b1, 12'o0000, 12'o0001, 12'o0000, 1'b1, 5'd23, 1);
    mode_instr(12'o7447);
    @(negedge clk);
    check("swba_mode", {31'd0, EAE_mode}, 32'd0);
    mode_instr(12'o7431);
`else
    check("swab_ignored", {31'd0, EAE_mode}, 32'd0);
    run_op("shl_a2",   12'o7413, 12'o0001, 12'o0000, 1'b0, 12'o0002, 12'o0010, 12'o0000, 1'b0, 5'd23, 3);
`endif

    // Abort a multiply part-way: no strobe, everything back to reset values.
    @(posedge clk); #1;
    state = S_EAE0; instruction = 12'o7405; ac_in = 12'o0001; mq_in = 12'o7777;
    link_in = 1'b1; operand = 12'o7777;
    @(posedge clk); #1;
    state = S_EAE1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1; state = S_IDLE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("abort");
    @(posedge clk); #1;
    reset = 1'b0;

    run_op("muy_after", 12'o7405, 12'o0000, 12'o0002, 1'b0, 12'o0003, 12'o0000, 12'o0006, 1'b0, 5'd0, 12);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eae_unit.md
Name: eae_unit

Overview:
- Extended Arithmetic Element datapath and sequencer for the PDP-8/e core.
- Sits directly downstream of the CPU state machine. It consumes the 5-bit major state and the current instruction.
- It produces EAE_mode and EAE_loop back to the state machine, and a result write-back to AC/MQ/L.
- Executes MUY, DIV, NMI, SHL, ASR and LSR, one iteration per clock in state EAE1.
- Tracks mode A/B via SWAB/SWBA.

Parameters:
- WIDTH, 12, word width. Fixed at 12; present for documentation only.
- SC_BITS, 5, step-counter width.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- state  input  5  CPU major state; codes from the shared parameters include (F3, EAE0, EAE1, ...)
- instruction  input  [0:11]  current instruction register
- ac_in  input  [0:11]  AC contents
- mq_in  input  [0:11]  MQ contents
- link_in  input  1  link
- operand  input  [0:11]  memory data: multiplier/divisor, or shift count in bits [7:11]; valid in EAE0
- ac_out  output  [0:11]  result AC
- mq_out  output  [0:11]  result MQ
- link_out  output  1  result link
- eae_we  output  1  one-cycle write-back strobe for AC/MQ/L
- sc  output  [4:0]  step counter (NMI shift count)
- EAE_mode  output  1  0 = mode A, 1 = mode B
- EAE_loop  output  1  hold state machine in EAE1

Behaviour:
- Reset: ac_out=0, mq_out=0, link_out=0, sc=0, EAE_mode=0, EAE_loop=0, eae_we=0, internal cnt=0.

Mode switching:
- SWAB (7431) sets EAE_mode=1 on the F3 edge.
- SWBA (7447) clears EAE_mode on the F3 edge.

EAE0 edge (single cycle):
- Latch ac_in, mq_in, link_in and operand into working registers.
- Decode the opcode from instruction[6:10] and load cnt:
  - MUY=12; DIV=12.
  - SHL/ASR/LSR = operand[7:11]+1 in mode A, operand[7:11] in mode B (range 0..32).
  - NMI=0, data-dependent.
- DIV overflow check: if AC >= divisor, set link, load cnt=0 and leave AC/MQ unchanged.

EAE1 (one iteration per clock):
- MUY: shift-add so that AC:MQ = MQ*operand + AC; link=0.
- DIV: restoring divide step; final state MQ=quotient, AC=remainder, link=0.
- SHL: AC:MQ shifted left by 1, zero into MQ[11], link <= AC[0].
- ASR: AC:MQ shifted right by 1, AC[0] replicated, link <= AC[0].
- LSR: AC:MQ shifted right by 1, zero fill, link=0.
- NMI: if not normalized, shift left by 1 and increment sc. Normalized means AC[0]!=AC[1], or AC:MQ==0, or AC:MQ==4000_0000 (octal).
- cnt decrements when nonzero. If cnt==0 on entry (count 0, DIV overflow), EAE1 performs no operation.

EAE_loop (combinational from registers, gated by state==EAE1):
- Non-NMI: EAE_loop = cnt>1. EAE1 therefore lasts max(cnt,1) cycles.
- NMI: EAE_loop = the value after this cycle's shift is not yet normalized.

Write-back and sc:
- On the final EAE1 edge (EAE_loop=0), copy working registers to ac_out/mq_out/link_out and set eae_we=1.
- eae_we clears on the next edge, so it is high for exactly the F3 cycle.
- sc: cleared at EAE0 for NMI; otherwise holds the last value.

Other rules:
- Non-EAE states: working registers hold, EAE_loop=0.
- Reset mid-operation aborts the operation: no eae_we pulse, and all outputs return to reset values.
- Arithmetic is unsigned 24-bit for MUY/DIV. Overflow of AC:MQ is impossible by construction.

Optional Feature:
- Macro EAE_MODE_B_EN.
- Defined: SWAB/SWBA are honoured, EAE_mode is a register, and mode-B shift counts apply.
- Undefined: EAE_mode is tied 0, SWAB/SWBA are ignored, and all shifts use the mode-A count+1 rule.

Test Plan:
- Reset asserted 2 clocks -> EAE_mode=0, EAE_loop=0, sc=0, eae_we=0, ac_out=mq_out=0.
- MUY, mode A, AC=0003, MQ=0012, operand=0005 -> EAE1 lasts 12 cycles, eae_we pulses once; AC=0000, MQ=0065, L=0.
- DIV, AC=0000, MQ=0144, operand=0007 -> MQ=0016, AC=0002, L=0.
- DIV overflow, AC=0010, operand=0007 -> EAE1 lasts 1 cycle; L=1, AC=0010, MQ unchanged.
- NMI, AC=0001, MQ=0000 -> 10 shifts, AC=2000, sc=10. NMI with AC:MQ=0 -> EAE1 lasts 1 cycle, sc=0.
- LSR mode A, count 0003, AC=0100 -> AC=0004, L=0. ASR count 0001, AC=4000 -> AC=7000, L=1. With EAE_MODE_B_EN: SWAB, then SHL count 0002, AC=0001 -> AC=0004 after 2 cycles.
